coupling_weight_loader: RTL and testbench

//  Host-side command engine driving the coupling-column array's config bus.

---
 rtl/coupling_weight_loader.sv | 147 ++++++++++++++
 tb/tb_coupling_weight_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/coupling_weight_loader.sv
// Command engine for the coupling-column config bus: validates a spin pair,
// derives the column, performs a single write or timed read and returns a response.
module coupling_weight_loader #(
  parameter int unsigned N       = 8,
  parameter int unsigned RD_WAIT = 2
) (
  input  logic                clk,
  input  logic                axi_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [15:0]         cmd_s,
  input  logic [15:0]         cmd_d,
  input  logic [31:0]         cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_err,
  output logic [31:0]         rsp_rdata,
  output logic                wready,
  output logic [N-2:0]        wr_match,
  output logic [15:0]         s_addr,
  output logic [15:0]         d_addr,
  output logic [31:0]         wdata,
  input  logic [32*(N-1)-1:0] col_rdata
);

  localparam int unsigned NC = N - 1;
  localparam int unsigned KW = $clog2(N);
  localparam int unsigned CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, CHK, WR, RDW, RSP} state_t;

  state_t        state;
  logic          write_q;
  logic [15:0]   s_q;
  logic [15:0]   d_q;
  logic [31:0]   wdata_q;
  logic [KW-1:0] k_q;
  logic [CW-1:0] cnt;

  logic          addr_err;
  logic [15:0]   lo;
  logic [15:0]   hi;
  logic [KW-1:0] k_next;
  logic [31:0]   col_word;

  // Pair validation and normalisation from the latched command
  always_comb begin
    addr_err = (s_q >= 16'(N)) || (d_q >= 16'(N)) || (s_q == d_q);
    lo       = (s_q < d_q) ? s_q : d_q;
    hi       = (s_q < d_q) ? d_q : s_q;
    k_next   = KW'(hi - lo - 16'd1);
  end

  // Read-data mux for the selected column
  always_comb begin
    col_word = '0;
    for (int i = 0; i < int'(NC); i++) begin
      if (KW'(i) == k_q) col_word = col_rdata[i*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wready    <= 1'b0;
      wr_match  <= '0;
      s_addr    <= '0;
      d_addr    <= '0;
      wdata     <= '0;
      write_q   <= 1'b0;
      s_q       <= '0;
      d_q       <= '0;
      wdata_q   <= '0;
      k_q       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            write_q   <= cmd_write;
            s_q       <= cmd_s;
            d_q       <= cmd_d;
            wdata_q   <= cmd_wdata;
            state     <= CHK;
          end
        end
        CHK: begin
          if (addr_err) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RSP;
          end else begin
            s_addr   <= lo;
            d_addr   <= hi;
            k_q      <= k_next;
            wr_match <= NC'(1) << k_next;
            if (write_q) begin
              wdata  <= wdata_q;
              wready <= 1'b1;
              state  <= WR;
            end else begin
              cnt   <= '0;
              state <= RDW;
            end
          end
        end
        WR: begin
          wready    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= RSP;
        end
        RDW: begin
          // Column read data is taken on the last wait cycle
          if (cnt == CW'(RD_WAIT - 1)) begin
            rsp_rdata <= col_word;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= RSP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wr_match  <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coupling_weight_loader.sv
// Directed bench for coupling_weight_loader with a response scoreboard and
// an independent model of pair validation, column selection and latency.
module tb_coupling_weight_loader;

  localparam int unsigned N       = 8;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned NC      = N - 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic                clk = 1'b0;
  logic                axi_rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_write = 1'b0;
  logic [15:0]         cmd_s = '0;
  logic [15:0]         cmd_d = '0;
  logic [31:0]         cmd_wdata = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic                rsp_err;
  logic [31:0]         rsp_rdata;
  logic                wready;
  logic [N-2:0]        wr_match;
  logic [15:0]         s_addr;
  logic [15:0]         d_addr;
  logic [31:0]         wdata;
  logic [32*NC-1:0]    col_rdata;

  logic [31:0] cols [NC];
  exp_t        exp_q [$];
  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  int          wready_cnt = 0;
  int          wm_cnt = 0;

  coupling_weight_loader #(.N(N), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .axi_rst(axi_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_s(cmd_s), .cmd_d(cmd_d), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .wready(wready), .wr_match(wr_match),
    .s_addr(s_addr), .d_addr(d_addr), .wdata(wdata), .col_rdata(col_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NC); i++) col_rdata[i*32 +: 32] = cols[i];
  end

  // Bus activity monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wready === 1'b1) wready_cnt++;
    if (wr_match !== '0) wm_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [15:0] s, input logic [15:0] d,
                      input logic [31:0] wd, input string tag);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_s = s; cmd_d = d; cmd_wdata = wd;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_accept_timeout"}, 32'(n), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic wr, input logic [15:0] s, input logic [15:0] d,
                        input logic [31:0] wd, input int hold, input string tag);
    exp_t        e;
    exp_t        got;
    logic        err;
    logic [15:0] lo, hi;
    int          k, lat, wr_base, wm_base;
    logic [31:0] held;

    err = (s >= 16'(N)) || (d >= 16'(N)) || (s == d);
    lo  = (s < d) ? s : d;
    hi  = (s < d) ? d : s;
    k   = int'(hi) - int'(lo) - 1;
    e.err   = err;
    e.rdata = (wr || err) ? 32'd0 : cols[k];
    e.lat   = err ? 2 : (wr ? 3 : 2 + int'(RD_WAIT));
    exp_q.push_back(e);

    wr_base = wready_cnt;
    wm_base = wm_cnt;
    send(wr, s, d, wd, tag);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
      return;
    end
    got = exp_q.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
    chk({tag, "_err"}, 32'(rsp_err), 32'(got.err));
    chk({tag, "_rdata"}, rsp_rdata, got.rdata);
    if (!err) begin
      chk({tag, "_wr_match"}, 32'(wr_match), 32'(1) << k);
      chk({tag, "_s_addr"}, 32'(s_addr), 32'(lo));
      chk({tag, "_d_addr"}, 32'(d_addr), 32'(hi));
      if (wr) chk({tag, "_wdata"}, wdata, wd);
    end

    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, held);
      chk({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_match_clear"}, 32'(wr_match), 32'd0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_wready_cycles"}, 32'(wready_cnt - wr_base), (wr && !err) ? 32'd1 : 32'd0);
    if (err) chk({tag, "_no_match"}, 32'(wm_cnt - wm_base), 32'd0);
  endtask

  initial begin
    int wr_base;
    for (int i = 0; i < int'(NC); i++) cols[i] = 32'h1000_0000 + 32'(i * 17);
    cols[6] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp", {29'd0, rsp_valid, rsp_err, wready}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_match", 32'(wr_match), 32'd0);
    chk("reset_addr", {s_addr, d_addr}, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    axi_rst = 1'b0;

    do_cmd(1'b1, 16'd2, 16'd5, 32'h0000_00A5, 0, "wr_2_5");
    do_cmd(1'b1, 16'd6, 16'd1, 32'h0000_1234, 0, "wr_6_1");
    do_cmd(1'b1, 16'd1, 16'd6, 32'h0000_1234, 0, "wr_1_6");
    do_cmd(1'b0, 16'd0, 16'd7, 32'd0, 0, "rd_0_7");
    do_cmd(1'b0, 16'd4, 16'd3, 32'd0, 0, "rd_4_3");
    do_cmd(1'b1, 16'd3, 16'd3, 32'h5555_5555, 0, "err_3_3");
    do_cmd(1'b0, 16'd8, 16'd0, 32'd0, 0, "err_8_0");
    do_cmd(1'b1, 16'd0, 16'hFFFF, 32'h1, 0, "err_0_ffff");
    do_cmd(1'b0, 16'd1, 16'd3, 32'd0, 5, "rd_hold");

    // Reset while the read is waiting on column data
    wr_base = wready_cnt;
    send(1'b0, 16'd0, 16'd7, 32'd0, "rst_rdw");
    @(posedge clk);
    #1;
    axi_rst = 1'b1;
    @(posedge clk);
    #1;
    axi_rst = 1'b0;
    chk("rst_rdw_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rdw_rsp", {29'd0, rsp_valid, rsp_err, wready}, 32'd0);
    chk("rst_rdw_match", 32'(wr_match), 32'd0);
    chk("rst_rdw_addr", {s_addr, d_addr}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_rdw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("rst_rdw_no_wready", 32'(wready_cnt - wr_base), 32'd0);
    do_cmd(1'b1, 16'd0, 16'd1, 32'hCAFE_F00D, 0, "post_rst_wr");
    do_cmd(1'b0, 16'd7, 16'd0, 32'd0, 0, "post_rst_rd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
